// File: rtl/uart_pkg.sv
// Shared types and register map for the MMIO UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    // Byte offsets inside the 8-byte window
    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd4;

    // STATUS bit positions
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 4;

    // Baud divider rounded to nearest integer
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a flop-based store; head word is read straight from the store.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rp_q];
    // Guard against illegal requests so pointers never desynchronise from count
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next-state for store, pointers and occupancy; pointers wrap at the power-of-two depth
    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wp_q] = din;
            wp_d        = wp_q + 1'b1;
        end
        if (do_pop) begin
            rp_d = rp_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Data store needs no reset: contents are only observed when count says valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: bus decode, overflow flag, 8N1 serialiser FSM.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int          CLK_HZ     = 27_000_000,
    parameter int          BAUD       = 115_200,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic        sel,
    output logic [31:0] rd,
    output logic        tx,
    output logic        irq
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int BW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_mmio: baud divider must be at least 2");
    end

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;

    logic          fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          is_status, push_req, ovf_clr, busy, baud_end;
    logic [31:0]   status;
    logic [9:0]    unused_bits;

    assign unused_bits = {addr[1:0], wd[31:24]};

    // Bus decode; addr[1:0] are don't-care inside the window
    assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
    assign is_status = (addr[2] == REG_STATUS[2]);
    assign push_req  = sel & we & ~is_status;
    // A push into a full FIFO is dropped even if a pop happens this cycle
    assign fifo_push = push_req & ~fifo_full;
    assign ovf_clr   = sel & we & is_status & wd[ST_OVF];

    assign busy = (state_q != IDLE);
    assign irq  = fifo_empty & ~busy;
    assign tx   = tx_q;

    always_comb begin
        status         = '0;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_BUSY]  = busy;
        status[ST_OVF]   = ovf_q;
        status[ST_CNT +: 4] = 4'(fifo_count);
    end

    assign rd = (sel && is_status) ? status : 32'h0;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wd[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow: set on a dropped push, cleared by writing 1 to STATUS bit3
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)               ovf_d = 1'b0;
        if (push_req && fifo_full) ovf_d = 1'b1;
    end

    assign baud_end = (baud_q == BAUD_LAST);

    // Serialiser next-state; tx_d is the level for the coming cycle so tx stays a pure flop
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d     = 1'b1;
                baud_d   = '0;
                bitcnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dout;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    tx_d    = shreg_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shreg_d = shreg_q >> 1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        tx_d     = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers; reset aborts any frame and returns the line high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed + randomized bench: line monitor decodes 8N1 frames, compared with written bytes.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam int          DIV   = 4;
    localparam int          FRAME = 10 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wd = 32'h0;
    logic        sel;
    logic [31:0] rd;
    logic        tx;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [9:0] rx_q [$];
    int         st_q [$];
    logic [7:0] exp_q [$];
    logic [9:0] mon_w;
    bit         mon_abort;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_mmio #(
        .CLK_HZ     (1_000_000),
        .BAUD       (250_000),
        .FIFO_DEPTH (8),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .addr  (addr),
        .wd    (wd),
        .sel   (sel),
        .rd    (rd),
        .tx    (tx),
        .irq   (irq)
    );

    // Line monitor: detect start bit, sample each bit mid-way, record {stop,data,start}
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                st_q.push_back(cyc);
                mon_abort = 1'b0;
                mon_w     = '0;
                for (int k = 1; k <= 38; k++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) mon_abort = 1'b1;
                    if ((k % 4) == 2) mon_w[(k - 2) / 4] = tx;
                end
                if (!mon_abort) rx_q.push_back(mon_w);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic rd_status(output logic [31:0] v);
        addr = BASE + 32'd4;
        #1;
        v = rd;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (irq !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic clear_q();
        rx_q.delete();
        st_q.delete();
        exp_q.delete();
    endtask

    // Every queued byte must come out framed, in order, with 1 idle cycle between frames
    task automatic check_frames(input string tag);
        chk({tag, "_nframes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk({tag, "_frame"}, {22'h0, rx_q[i]}, {22'h0, 1'b1, exp_q[i], 1'b0});
        for (int i = 1; i < st_q.size(); i++)
            chk({tag, "_gap"}, st_q[i] - st_q[i-1], FRAME + 1);
    endtask

    initial begin
        logic [31:0] s;
        int          n;
        int          nb;
        bit          low_seen;

        // 1: reset
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_tx", tx, 1);
        chk("rst_irq", irq, 1);
        rd_status(s);
        chk("rst_status", s, 32'h2);
        chk("rst_sel", sel, 1);
        addr = BASE;
        #1;
        chk("txdata_read", rd, 0);

        // 2: single byte 0x55
        clear_q();
        exp_q.push_back(8'h55);
        wr(BASE, 32'h55);
        rd_status(s);
        chk("b55_queued", s, 32'h10);
        chk("b55_irq_low", irq, 0);
        tick();
        rd_status(s);
        chk("b55_busy", s, 32'h6);
        chk("b55_start", tx, 0);
        wait_idle(100, n);
        chk("b55_irq_delay", n, FRAME);
        check_frames("b55");

        // 3: overflow; first byte popped at once, next 8 fill the FIFO, 10th dropped
        clear_q();
        for (int i = 0; i < 9; i++) begin
            wr(BASE, i);
            exp_q.push_back(8'(i));
        end
        rd_status(s);
        chk("ovf_full", s, 32'h85);
        wr(BASE, 32'h9);
        rd_status(s);
        chk("ovf_set", s, 32'h8D);
        wait_idle(FRAME * 10 + 20, n);
        chk("ovf_drain_to", irq, 1);
        check_frames("ovf");
        wr(BASE + 32'd4, 32'h8);
        rd_status(s);
        chk("ovf_clear", s, 32'h2);

        // 4: back-to-back bursts, first directed then random
        for (int r = 0; r < 5; r++) begin
            clear_q();
            nb = (r == 0) ? 2 : $urandom_range(1, 4);
            for (int i = 0; i < nb; i++) begin
                if (r == 0) exp_q.push_back((i == 0) ? 8'hA5 : 8'h3C);
                else        exp_q.push_back(8'($urandom));
                wr(BASE, {$urandom, 8'h0} | {24'h0, exp_q[i]});
            end
            wait_idle(FRAME * 5 + 20, n);
            chk("burst_done", irq, 1);
            check_frames("burst");
        end

        // 5: reset during data bit 3 with a full FIFO and ovf set
        clear_q();
        for (int i = 0; i < 10; i++) wr(BASE, (i == 0) ? 32'h08 : 32'hFF);
        rd_status(s);
        chk("mid_pre", s, 32'h8D);
        repeat (9) tick();
        chk("mid_bit3", tx, 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_irq", irq, 1);
        rd_status(s);
        chk("mid_rst_status", s, 32'h2);
        tick();
        rst_n = 1'b1;
        clear_q();
        low_seen = 1'b0;
        repeat (60) begin
            tick();
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        chk("mid_no_frame", low_seen, 0);
        chk("mid_no_rx", rx_q.size(), 0);

        // 6: writes outside the window have no effect
        addr = BASE + 32'd8;
        wd   = 32'h77;
        we   = 1'b1;
        #1;
        chk("miss8_sel", sel, 0);
        chk("miss8_rd", rd, 0);
        tick();
        addr = 32'h0;
        #1;
        chk("miss0_sel", sel, 0);
        chk("miss0_rd", rd, 0);
        tick();
        we = 1'b0;
        rd_status(s);
        chk("miss_status", s, 32'h2);
        low_seen = 1'b0;
        repeat (50) begin
            tick();
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        chk("miss_tx_idle", low_seen, 0);
        chk("miss_no_rx", rx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
